// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Raster timing generator (default 1024x768@60 Hz XGA, 65 MHz
//                pclk). Produces registered counters, sync and blank flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
   parameter int   H_ACTIVE = 1024,
   parameter int   H_FP     = 24,
   parameter int   H_SYNC   = 136,
   parameter int   H_BP     = 160,
   parameter int   V_ACTIVE = 768,
   parameter int   V_FP     = 3,
   parameter int   V_SYNC   = 6,
   parameter int   V_BP     = 29,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        pclk,
   input  logic        rst,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
   localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_BLANK_START = 11'(V_ACTIVE);
   localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic        h_wrap;
   logic        v_wrap;
   logic [10:0] hcount_next;
   logic [10:0] vcount_next;
   logic        hsync_next;
   logic        hblnk_next;
   logic        vsync_next;
   logic        vblnk_next;
   logic        frame_start_next;

   // Flags are decoded from the next counter values so that, once registered,
   // they line up with the counters on the same cycle.
   always_comb begin
      // >= keeps the counters bounded even if they were ever out of range
      h_wrap = (hcount_out >= H_LAST);
      v_wrap = (vcount_out >= V_LAST);

      hcount_next = h_wrap ? 11'd0 : hcount_out + 11'd1;

      vcount_next = vcount_out;
      if (h_wrap) begin
         vcount_next = v_wrap ? 11'd0 : vcount_out + 11'd1;
      end

      hblnk_next = (hcount_next >= H_BLANK_START);
      vblnk_next = (vcount_next >= V_BLANK_START);

      hsync_next = ((hcount_next >= H_SYNC_START) && (hcount_next <= H_SYNC_END))
                   ? SYNC_POL : ~SYNC_POL;
      vsync_next = ((vcount_next >= V_SYNC_START) && (vcount_next <= V_SYNC_END))
                   ? SYNC_POL : ~SYNC_POL;

      // Only a genuine end-of-frame wrap marks a frame start
      frame_start_next = h_wrap && v_wrap;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_out  <= 11'd0;
         vcount_out  <= 11'd0;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         hsync_out   <= ~SYNC_POL;
         vsync_out   <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         hcount_out  <= hcount_next;
         vcount_out  <= vcount_next;
         hblnk_out   <= hblnk_next;
         vblnk_out   <= vblnk_next;
         hsync_out   <= hsync_next;
         vsync_out   <= vsync_next;
         frame_start <= frame_start_next;
      end
   end

endmodule
`default_nettype wire
